jk_excitation_driver: RTL
=========================

Name: jk_excitation_driver

Overview:
- Inverse of the JK flip-flop. It accepts a target word, applies the JK excitation table against the live Q feedback of an external WIDTH-bit bank of jkff cells, and drives J/K for one clock.
- It then checks that the bank reached the target, retrying up to a limit before it flags an error.
- It sits upstream of the jkff bank as its stimulus/controller, replacing hand-written J/K sequences.

Parameters:
- WIDTH, 4: number of JK flip-flops driven (bits of tgt, q_fb, J, K).
- MAX_RETRY, 2: re-drive attempts after the first failed check before err is raised.
- TOGGLE_MODE, 0: 0 resolves don't-cares to 0 (set/reset/hold only); 1 resolves them to 1 (changes use J=K=1 toggle).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- tgt_valid  input  1  target word offered.
- tgt_ready  output  1  block idle, can accept a target.
- tgt  input  WIDTH  desired next Q of the bank.
- q_fb  input  WIDTH  Q outputs of the external jkff bank.
- J  output  WIDTH  J inputs to the bank, registered.
- K  output  WIDTH  K inputs to the bank, registered.
- busy  output  1  transaction in progress (not IDLE).
- done  output  1  one-cycle pulse: bank matched the target.
- err  output  1  one-cycle pulse: retries exhausted, bank did not match.
- mismatch  output  WIDTH  registered tgt_r XOR q_fb from the last check; held until the next check.

Behaviour:
- Reset (async, rst=1): state=IDLE, J=0, K=0, done=0, err=0, mismatch=0, retry count=0, tgt_r=0. The outputs then read tgt_ready=1, busy=0.
  - Reset asserted mid-transaction aborts it immediately.
  - No done or err is produced for the aborted transaction.
- Excitation per bit i (cur=q_fb[i], nxt=target bit):
  - TOGGLE_MODE=0: 0->0 J=0,K=0; 0->1 J=1,K=0; 1->0 J=0,K=1; 1->1 J=0,K=0.
  - TOGGLE_MODE=1: 0->0 J=0,K=0; 0->1 J=1,K=1; 1->0 J=1,K=1; 1->1 J=0,K=0.
  - J=K=1 is never driven when TOGGLE_MODE=0.
- States: IDLE, DRIVE, CHECK.
- IDLE:
  - tgt_ready=1, busy=0, J=K=0.
  - On tgt_valid=1 at a clk edge: capture tgt into tgt_r, register J/K from tgt vs the current q_fb, clear retry count, go to DRIVE.
  - tgt_valid=0 leaves the block in IDLE.
- DRIVE (exactly 1 cycle):
  - J/K are held stable for the whole cycle; the external bank samples them at the closing edge.
  - At that edge J=K=0 and the state goes to CHECK.
- CHECK (1 cycle): compare q_fb against tgt_r; register mismatch = tgt_r ^ q_fb.
  - Equal: done=1 for the next cycle, state goes to IDLE.
  - Unequal and retry count < MAX_RETRY: increment the count, recompute J/K from tgt_r vs the current q_fb, go to DRIVE.
  - Unequal and retry count == MAX_RETRY: err=1 for the next cycle, state goes to IDLE.
- Latency:
  - Accept at edge 0; DRIVE is cycle 1; CHECK is cycle 2; done or err is high in cycle 3.
  - tgt_ready is also 1 in cycle 3, so a new target may be accepted on the edge ending cycle 3.
  - Worst case to err: 2*(MAX_RETRY+1)+1 cycles.
- Handshake:
  - tgt is sampled only when tgt_valid=1 and tgt_ready=1.
  - tgt and tgt_valid are ignored while busy.
- Boundary conditions:
  - Target equal to the current Q: J=K=0 is driven, CHECK passes, done is asserted.
  - done and err are never asserted together.
  - A new accept is allowed in the same cycle done or err is high; that pulse still lasts exactly one cycle.

Test Plan (WIDTH=4, MAX_RETRY=2, bench instantiates four jkff cells fed by J/K, q_fb tied to their Q):
1. Reset, bank Q=0000, tgt=1010, TOGGLE_MODE=0 -> in DRIVE J=1010, K=0000; done pulses in cycle 3; Q=1010; mismatch=0000; err stays 0.
2. From Q=1010, tgt=0110 -> J=0100, K=1000; done in cycle 3; Q=0110.
3. TOGGLE_MODE=1, from Q=0110, tgt=1001 -> J=1111, K=1111 for one cycle; Q=1001; done.
4. Bank bit 0 forced stuck at 0, tgt=0001 -> three DRIVE/CHECK rounds, J[0]=1 each round; err pulses at cycle 7; mismatch=0001; done=0.
5. tgt_valid held high with tgt=1111 then 0000 -> second target is accepted only on the cycle done is high; no word is accepted while busy=1.
6. Reset asserted during DRIVE -> J=K=0 and tgt_ready=1 immediately (asynchronous); no done or err; the next accepted target completes normally.

Source files
------------

// File: rtl/jk_excitation_driver.sv
// Drives J/K into an external JK flip-flop bank so that it reaches a requested target word,
// then confirms the bank's Q against the target and re-drives a bounded number of times.
module jk_excitation_driver #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned MAX_RETRY   = 2,
    parameter int unsigned TOGGLE_MODE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] mismatch
);

    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   j_q, j_d;
    logic [WIDTH-1:0]   k_q, k_d;
    logic [WIDTH-1:0]   tgt_r_q, tgt_r_d;
    logic [WIDTH-1:0]   mismatch_q, mismatch_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [WIDTH-1:0]   exc_nxt;
    logic [WIDTH-1:0]   exc_j;
    logic [WIDTH-1:0]   exc_k;

    // Excitation against live Q: new target when idle, captured target on a retry.
    always_comb begin
        exc_nxt = (state_q == IDLE) ? tgt : tgt_r_q;
        if (TOGGLE_MODE != 0) begin
            exc_j = q_fb ^ exc_nxt;
            exc_k = q_fb ^ exc_nxt;
        end else begin
            exc_j = ~q_fb & exc_nxt;
            exc_k = q_fb & ~exc_nxt;
        end
    end

    always_comb begin
        state_d    = state_q;
        j_d        = '0;
        k_d        = '0;
        tgt_r_d    = tgt_r_q;
        mismatch_d = mismatch_q;
        retry_d    = retry_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (tgt_valid) begin
                    tgt_r_d = tgt;
                    j_d     = exc_j;
                    k_d     = exc_k;
                    retry_d = '0;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                state_d = CHECK;
            end
            CHECK: begin
                mismatch_d = tgt_r_q ^ q_fb;
                if (q_fb == tgt_r_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
                    retry_d = retry_q + RETRY_W'(1);
                    j_d     = exc_j;
                    k_d     = exc_k;
                    state_d = DRIVE;
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            j_q        <= '0;
            k_q        <= '0;
            tgt_r_q    <= '0;
            mismatch_q <= '0;
            retry_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            j_q        <= j_d;
            k_q        <= k_d;
            tgt_r_q    <= tgt_r_d;
            mismatch_q <= mismatch_d;
            retry_q    <= retry_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign J         = j_q;
    assign K         = k_q;
    assign done      = done_q;
    assign err       = err_q;
    assign mismatch  = mismatch_q;
    assign tgt_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);

endmodule
